// File: rtl/digit_scan_ctrl_pkg.sv
// Shared constants and types for the four-digit multiplexed display scanner.
package digit_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int SEL_W      = 2;
    localparam int FRAME_W    = NUM_DIGITS * NIBBLE_W;

    typedef logic [SEL_W-1:0]      sel_t;
    typedef logic [NUM_DIGITS-1:0] an_t;
    typedef logic [NIBBLE_W-1:0]   nibble_t;

    localparam an_t  AN_ALL_OFF = 4'b1111;
    localparam sel_t SEL_LAST   = sel_t'(NUM_DIGITS - 1);

    // Active-low, one-cold anode pattern for the selected digit, or all off when masked.
    function automatic an_t an_decode(input sel_t sel, input an_t en);
        an_t an;
        an = AN_ALL_OFF;
        if (en[sel]) an[sel] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: counts 0..DIV-1 and flags the last count of each slot.
module scan_prescaler #(
    parameter  int DIV = 50000,
    localparam int CW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] count,
    output logic          wrap
);

    assign wrap = (count == CW'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit scan controller with double-buffered, tear-free frame loading.
// Optional anti-ghosting blanking at the start of each slot: define SCAN_BLANK_EN.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [FRAME_W-1:0]    load_data,
    input  logic [NUM_DIGITS-1:0] dig_en,
    output logic [SEL_W-1:0]      S,
    output logic [NIBBLE_W-1:0]   D0,
    output logic [NIBBLE_W-1:0]   D1,
    output logic [NIBBLE_W-1:0]   D2,
    output logic [NIBBLE_W-1:0]   D3,
    output logic [NUM_DIGITS-1:0] AN,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]   count;
    logic               tick;
    logic [CNT_W-1:0]   next_count;
    sel_t               next_sel;
    logic               frame_end;
    logic               accept;
    logic               blank;
    logic               pending;
    logic [FRAME_W-1:0] shadow;
    nibble_t            disp [NUM_DIGITS];

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .wrap  (tick)
    );

    assign next_count = tick ? '0 : count + CNT_W'(1);
    assign next_sel   = tick ? S + sel_t'(1) : S;
    assign frame_end  = tick && (S == SEL_LAST);
    assign accept     = load_valid && !pending;
    assign load_ready = !pending;

`ifdef SCAN_BLANK_EN
    assign blank = (next_count < CNT_W'(BLANK));
`else
    logic unused_blank;
    assign unused_blank = (BLANK < DIV);
    assign blank        = 1'b0;
`endif

    // AN and frame_done are computed from next-state values so they change on the same edge as S.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S          <= '0;
            AN         <= AN_ALL_OFF;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            shadow     <= '0;
            // NOTE: the display nibbles are a handful of flops, not RAM, so they are reset like any register.
            for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= '0;
        end else begin
            S          <= next_sel;
            AN         <= blank ? AN_ALL_OFF : an_decode(next_sel, dig_en);
            frame_done <= frame_end;
            if (frame_end) begin
                for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= shadow[i*NIBBLE_W +: NIBBLE_W];
                pending <= 1'b0;
            end
            // Placed after the transfer so a handshake on the wrap edge re-arms pending.
            if (accept) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end
        end
    end

    assign D0 = disp[0];
    assign D1 = disp[1];
    assign D2 = disp[2];
    assign D3 = disp[3];

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed, table-driven bench for digit_scan_ctrl with DIV=8, BLANK=2.
module tb_digit_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  dig_en;
    logic [1:0]  S;
    logic [3:0]  D0, D1, D2, D3;
    logic [3:0]  AN;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    digit_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dig_en     (dig_en),
        .S          (S),
        .D0         (D0),
        .D1         (D1),
        .D2         (D2),
        .D3         (D3),
        .AN         (AN),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          adv;    // rising edges to advance before sampling
        logic [3:0]  en;
        logic        lv;     // load_valid held for the first edge only
        logic [15:0] ld;
        logic [1:0]  s;
        logic [3:0]  an;
        logic [15:0] d;      // {D3,D2,D1,D0}
        logic        rdy;
        logic        fd;
        logic        early;  // sample falls in prescaler counts 0..BLANK-1
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] s, input logic [3:0] an,
                                 input logic [15:0] d, input logic rdy, input logic fd);
        check({tag, ".S"},          32'(S), 32'(s));
        check({tag, ".AN"},         32'(AN), 32'(an));
        check({tag, ".D"},          32'({D3, D2, D1, D0}), 32'(d));
        check({tag, ".load_ready"}, 32'(load_ready), 32'(rdy));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
    endtask

    // Called on a falling edge; returns on a later falling edge.
    task automatic advance(input int k, input logic lv, input logic [15:0] ld);
        load_valid = lv;
        load_data  = ld;
        @(posedge clk);
        #1 load_valid = 1'b0;
        for (int i = 1; i < k; i++) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Cycle n = rising edges since reset release; S = (n/8)%4, count = n%8.
        vecs[0]  = '{4,  4'hF, 1'b0, 16'h0000, 2'd0, 4'hE, 16'h0000, 1'b1, 1'b0, 1'b0}; // n=4
        vecs[1]  = '{8,  4'hF, 1'b0, 16'h0000, 2'd1, 4'hD, 16'h0000, 1'b1, 1'b0, 1'b0}; // n=12
        vecs[2]  = '{8,  4'hF, 1'b0, 16'h0000, 2'd2, 4'hB, 16'h0000, 1'b1, 1'b0, 1'b0}; // n=20
        vecs[3]  = '{8,  4'hF, 1'b0, 16'h0000, 2'd3, 4'h7, 16'h0000, 1'b1, 1'b0, 1'b0}; // n=28
        vecs[4]  = '{4,  4'hF, 1'b0, 16'h0000, 2'd0, 4'hE, 16'h0000, 1'b1, 1'b1, 1'b1}; // n=32 wrap
        vecs[5]  = '{1,  4'hF, 1'b0, 16'h0000, 2'd0, 4'hE, 16'h0000, 1'b1, 1'b0, 1'b1}; // n=33
        vecs[6]  = '{11, 4'hF, 1'b0, 16'h0000, 2'd1, 4'hD, 16'h0000, 1'b1, 1'b0, 1'b0}; // n=44
        vecs[7]  = '{1,  4'hF, 1'b1, 16'hA5C3, 2'd1, 4'hD, 16'h0000, 1'b0, 1'b0, 1'b0}; // n=45 accepted
        vecs[8]  = '{18, 4'hF, 1'b0, 16'h0000, 2'd3, 4'h7, 16'h0000, 1'b0, 1'b0, 1'b0}; // n=63
        vecs[9]  = '{1,  4'hF, 1'b0, 16'h0000, 2'd0, 4'hE, 16'hA5C3, 1'b1, 1'b1, 1'b1}; // n=64 shown
        vecs[10] = '{1,  4'hF, 1'b1, 16'h1234, 2'd0, 4'hE, 16'hA5C3, 1'b0, 1'b0, 1'b1}; // n=65 accepted
        vecs[11] = '{1,  4'hF, 1'b1, 16'h5678, 2'd0, 4'hE, 16'hA5C3, 1'b0, 1'b0, 1'b0}; // n=66 refused
        vecs[12] = '{30, 4'hF, 1'b0, 16'h0000, 2'd0, 4'hE, 16'h1234, 1'b1, 1'b1, 1'b1}; // n=96
        vecs[13] = '{31, 4'hF, 1'b0, 16'h0000, 2'd3, 4'h7, 16'h1234, 1'b1, 1'b0, 1'b0}; // n=127
        vecs[14] = '{1,  4'hF, 1'b1, 16'hBEEF, 2'd0, 4'hE, 16'h1234, 1'b0, 1'b1, 1'b1}; // n=128 wrap+load
        vecs[15] = '{32, 4'hF, 1'b0, 16'h0000, 2'd0, 4'hE, 16'hBEEF, 1'b1, 1'b1, 1'b1}; // n=160
        vecs[16] = '{4,  4'h5, 1'b0, 16'h0000, 2'd0, 4'hE, 16'hBEEF, 1'b1, 1'b0, 1'b0}; // n=164
        vecs[17] = '{8,  4'h5, 1'b0, 16'h0000, 2'd1, 4'hF, 16'hBEEF, 1'b1, 1'b0, 1'b0}; // n=172
        vecs[18] = '{8,  4'h5, 1'b0, 16'h0000, 2'd2, 4'hB, 16'hBEEF, 1'b1, 1'b0, 1'b0}; // n=180
        vecs[19] = '{8,  4'h5, 1'b0, 16'h0000, 2'd3, 4'hF, 16'hBEEF, 1'b1, 1'b0, 1'b0}; // n=188

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        dig_en     = 4'hF;
        repeat (3) @(negedge clk);
        check_outputs("reset", 2'd0, 4'hF, 16'h0000, 1'b1, 1'b0);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            logic [3:0] exp_an;
            exp_an = vecs[v].an;
`ifdef SCAN_BLANK_EN
            if (vecs[v].early) exp_an = 4'hF;
`endif
            dig_en = vecs[v].en;
            advance(vecs[v].adv, vecs[v].lv, vecs[v].ld);
            check_outputs($sformatf("vec%0d", v), vecs[v].s, exp_an, vecs[v].d,
                          vecs[v].rdy, vecs[v].fd);
        end

        // Reset during slot 2 with a frame pending: everything returns to reset values at once.
        dig_en = 4'hF;
        advance(12, 1'b0, 16'h0000);                          // n=200, S=1
        advance(1, 1'b1, 16'h1357);                           // n=201, frame pending
        advance(10, 1'b0, 16'h0000);                          // n=211, S=2 count=3
        check("pre_reset.S", 32'(S), 32'd2);
        check("pre_reset.load_ready", 32'(load_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 2'd0, 4'hF, 16'h0000, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cycle-by-cycle after release: slot timing, AN pattern, frame pulse, discarded frame.
        for (int n = 1; n <= 40; n++) begin
            logic [1:0] exp_s;
            logic [3:0] exp_an;
            @(negedge clk);
            exp_s  = 2'((n / DIV) % 4);
            exp_an = 4'hF & ~(4'b0001 << exp_s);
`ifdef SCAN_BLANK_EN
            if ((n % DIV) < BLANK) exp_an = 4'hF;
`endif
            check_outputs($sformatf("post_reset_n%0d", n), exp_s, exp_an, 16'h0000, 1'b1,
                          ((n % (4 * DIV)) == 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot (legal range 8..2^20).
REQ-002 SHALL have parameter BLANK, default 4, meaning blanking cycles at the start of each slot (used only when SCAN_BLANK_EN is defined; BLANK < DIV).
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_valid  input  1  a new frame is offered.
REQ-006 SHALL have port load_ready  output  1  the block can accept a frame.
REQ-007 SHALL have port load_data  input  16  frame: [3:0] digit0, [7:4] digit1, [11:8] digit2, [15:12] digit3.
REQ-008 SHALL have port dig_en  input  4  per-digit enable mask, 1 = digit shown.
REQ-009 SHALL have port S  output  2  select to downstream 4:1 nibble mux.
REQ-010 SHALL have ports D0, D1, D2, D3  output  4 each  displayed nibbles to the mux data inputs.
REQ-011 SHALL have port AN  output  4  digit anode drive, active-low, one-cold.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when slot 3 ends.

Function
REQ-013 SHALL accept a frame on a clk edge where load_valid and load_ready are both 1, storing it in a shadow register and setting pending.
REQ-014 SHALL drive load_ready = !pending; load_data is ignored while load_ready is 0.
REQ-015 SHALL count cycles 0..DIV-1 per slot in a prescaler; at DIV-1 the prescaler wraps to 0 and S increments, wrapping 3 -> 0.
REQ-016 SHALL pulse frame_done for the single cycle in which S wraps 3 -> 0.
REQ-017 SHALL copy the shadow to D0..D3 and clear pending on that same wrap edge only (tear-free update); the frame is visible from the first cycle with S = 0.
REQ-018 SHALL, if a handshake and a wrap occur on the same edge, capture into the shadow and set pending; the transfer occurs at the next wrap.
REQ-019 SHALL drive AN[S] = 0 and all other AN bits = 1 when dig_en[S] = 1; all AN = 1 when dig_en[S] = 0.
REQ-020 SHALL make AN a registered output, aligned with S (same cycle S changes, AN changes).
REQ-021 SHALL sample dig_en combinationally each cycle; a mask change takes effect on AN on the next edge.
REQ-022 SHALL keep S, D0..D3 stable for exactly DIV cycles per slot; full frame period = 4*DIV cycles.

Reset
REQ-023 SHALL on rst_n = 0, asynchronously: S = 0, prescaler = 0, D0..D3 = 0, shadow = 0, pending = 0 (load_ready = 1), AN = 4'b1111, frame_done = 0.
REQ-024 SHALL discard any pending frame on reset mid-operation; first slot after release starts with the prescaler at 0 and S = 0.

Configuration
REQ-025 SHALL, with SCAN_BLANK_EN defined, force AN = 4'b1111 during prescaler counts 0..BLANK-1 of every slot (anti-ghosting); S and D timing unchanged.
REQ-026 SHALL, without SCAN_BLANK_EN, ignore BLANK and drive AN per REQ-019 for the full slot.

Structure
REQ-027 SHALL place in a shared package: digit count (4), nibble width (4), select width (2), the AN all-off constant 4'b1111.
REQ-028 SHALL implement the prescaler as one sub-module scan_prescaler (parameter DIV, outputs count and wrap tick); everything else in digit_scan_ctrl.

Verification
REQ-029 SHALL check: reset release with DIV=8, dig_en=4'b1111 -> S steps 0,1,2,3,0 every 8 cycles, AN = 1110,1101,1011,0111, frame_done pulses once per 32 cycles.
REQ-030 SHALL check: load 16'hA5C3 mid-slot-1 -> load_ready drops next cycle; D0..D3 = 3,C,5,A appear exactly at the S 3->0 wrap, load_ready returns 1 then.
REQ-031 SHALL check: second load_valid while pending -> not accepted; first frame displayed, second accepted only after wrap.
REQ-032 SHALL check: handshake on the wrap edge -> old frame shown for that frame, new one at following wrap.
REQ-033 SHALL check: dig_en=4'b0101 -> AN = 1110, 1111, 1011, 1111 across slots; with SCAN_BLANK_EN, BLANK=2 -> AN = 1111 for first 2 cycles of each slot.
REQ-034 SHALL check: rst_n low during slot 2 with frame pending -> all outputs to reset values immediately; load_ready = 1, D0..D3 = 0 after release.
